tdm_demux4: RTL and testbench
=============================

# tdm_demux4

Receive-side counterpart of the 4:1 word multiplexer. Accepts a time-division-multiplexed stream of N-bit words, one per slot, four slots per frame, with slot 0 flagged by `frame_start`. Rebuilds the four parallel channels and presents them together on registered outputs, with a one-cycle `out_valid` pulse per completed frame. Sits after any link that walks `select` 0→3 over a 4:1 mux.

## Interface
- `N`, default 4: word width of each channel.
- `clk`  input  1  rising-edge clock.
- `rst_n`  input  1  asynchronous, active-low reset.
- `in`  input  N  TDM data word.
- `in_valid`  input  1  `in` is sampled this cycle.
- `frame_start`  input  1  qualifies the current valid word as slot 0; ignored when `in_valid`=0.
- `out0`..`out3`  output  N each  channel words of the last complete frame.
- `out_valid`  output  1  one-cycle pulse: `out0`..`out3` were just updated.
- `slot`  output  2  index the next valid word will fill.
- `frame_error`  output  1  one-cycle pulse on a framing violation.

## Operation
- States: HUNT (no frame in progress), RECEIVE (slots 1..3 pending or next frame expected).
- Reset values: state HUNT, `slot`=0, shadow words 0, `out0`..`out3`=0, `out_valid`=0, `frame_error`=0.
- HUNT:
  - `in_valid`&&`frame_start`: shadow0←`in`, `slot`←1, go to RECEIVE.
  - `in_valid`&&!`frame_start`: word dropped, no error.
- RECEIVE, on `in_valid`:
  - `frame_start`=0, `slot`∈{1,2}: shadow[`slot`]←`in`, `slot`++.
  - `frame_start`=0, `slot`=3: `out0..2`←shadow0..2 and `out3`←`in`, all in the same edge. `out_valid` pulses next cycle. `slot`←0, stay in RECEIVE.
  - `frame_start`=1, `slot`=0: normal next frame. shadow0←`in`, `slot`←1.
  - `frame_start`=1, `slot`≠0 (early start): `frame_error` pulses. Partial frame is discarded. The word is taken as slot 0: shadow0←`in`, `slot`←1.
  - `frame_start`=0, `slot`=0 (missing start): `frame_error` pulses, word dropped, `slot`←0, go to HUNT.
- `in_valid`=0: nothing changes, any slot. Gaps between slots are legal and unbounded.
- `out0`..`out3` change only on frame completion. They hold otherwise, including across errors.
- `slot` arithmetic: 2-bit, wraps 3→0 only on completion.

## Timing
- All outputs are registered; there is no combinational path from inputs to outputs.
- Latency: the slot-3 word is sampled on edge k. New `out0`..`out3` and `out_valid`=1 are visible after edge k and stay valid for cycle k+1. `out_valid` falls after edge k+1 unless that edge completes another frame, which cannot happen.
- `frame_error` is high for exactly the cycle after the offending sampling edge.
- Back-to-back frames with `in_valid` held high give an `out_valid` pulse every 4 cycles, with no bubble.
- `rst_n` low mid-frame immediately clears state, shadows, outputs and pulses, independent of `clk`. The first valid word after release must carry `frame_start`.

## Structure
- Package `tdm_pkg`:
  - `typedef enum logic {HUNT, RECEIVE} tdm_state_t`.
  - `localparam SLOTS = 4`.
  - `typedef logic [1:0] slot_t`.
- One sub-module, `tdm_slot_reg #(.N(N))`: N-bit register with enable and async active-low clear. Instantiated for shadow0..2 and out0..3.
- FSM, slot counter and pulse flops stay inline in `tdm_demux4`.

## Test plan
- Single frame, N=4: words 1,2,3,4 with `frame_start` on 1 and `in_valid` high for 4 cycles → one `out_valid` pulse with outs=1,2,3,4 on the cycle after the 4th word; `frame_error` stays 0.
- Gapped frame: same words with `in_valid` low for 3 cycles between each → identical outputs; `out_valid` pulses once; `slot` steps 1,2,3,0 only on valid cycles.
- Back-to-back: frames (1,2,3,4) then (5,6,7,8) continuous → `out_valid` pulses 4 cycles apart; outs 1,2,3,4 then 5,6,7,8.
- Early start: 1(fs),2,9(fs),10,11,12 → `frame_error` pulses after the word 9 edge; outs=9,10,11,12; previous outs held until then.
- Missing start and hunt: after a complete frame, send 7 without fs → `frame_error`, state HUNT. Then 3,3 without fs → no error, no output. Then 1(fs),2,3,4 → outs=1,2,3,4.
- Reset mid-frame: 1(fs),2, then `rst_n` low between edges → outs, `slot` and `out_valid` go to 0 immediately. After release, 3,4 without fs → nothing captured.

Source files
------------

// File: rtl/tdm_pkg.sv
// Shared types and constants for the 4-slot TDM receive path.
package tdm_pkg;

  typedef enum logic {HUNT, RECEIVE} tdm_state_t;

  localparam int SLOTS = 4;

  typedef logic [1:0] slot_t;

endpackage

// File: rtl/tdm_demux4_slot_reg.sv
// N-bit holding register with load enable and asynchronous active-low clear.
module tdm_slot_reg #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);

  logic [N-1:0] q_d;

  always_comb begin
    q_d = q;
    if (en) q_d = d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= '0;
    else        q <= q_d;
  end

endmodule

// File: rtl/tdm_demux4.sv
// Rebuilds four parallel channels from a framed TDM word stream and
// presents each completed frame on registered outputs with a valid pulse.
module tdm_demux4
  import tdm_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] in,
  input  logic         in_valid,
  input  logic         frame_start,
  output logic [N-1:0] out0,
  output logic [N-1:0] out1,
  output logic [N-1:0] out2,
  output logic [N-1:0] out3,
  output logic         out_valid,
  output logic [1:0]   slot,
  output logic         frame_error
);

  localparam slot_t LAST_SLOT = slot_t'(SLOTS - 1);

  tdm_state_t   state_q, state_d;
  slot_t        slot_q, slot_d;
  logic         out_valid_q, out_valid_d;
  logic         frame_error_q, frame_error_d;
  logic [2:0]   shadow_en;
  logic         out_en;
  logic [N-1:0] shadow0_q, shadow1_q, shadow2_q;

  always_comb begin
    state_d       = state_q;
    slot_d        = slot_q;
    out_valid_d   = 1'b0;
    frame_error_d = 1'b0;
    shadow_en     = 3'b000;
    out_en        = 1'b0;
    if (in_valid) begin
      unique case (state_q)
        HUNT: begin
          if (frame_start) begin
            shadow_en[0] = 1'b1;
            slot_d       = 2'd1;
            state_d      = RECEIVE;
          end
        end
        RECEIVE: begin
          // A start flag always restarts the frame; mid-frame it also flags an error.
          if (frame_start) begin
            frame_error_d = (slot_q != 2'd0);
            shadow_en[0]  = 1'b1;
            slot_d        = 2'd1;
          end else begin
            unique case (slot_q)
              2'd0: begin
                frame_error_d = 1'b1;
                state_d       = HUNT;
              end
              2'd1: begin
                shadow_en[1] = 1'b1;
                slot_d       = 2'd2;
              end
              2'd2: begin
                shadow_en[2] = 1'b1;
                slot_d       = LAST_SLOT;
              end
              default: begin
                out_en      = 1'b1;
                out_valid_d = 1'b1;
                slot_d      = 2'd0;
              end
            endcase
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= HUNT;
      slot_q        <= 2'd0;
      out_valid_q   <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      slot_q        <= slot_d;
      out_valid_q   <= out_valid_d;
      frame_error_q <= frame_error_d;
    end
  end

  tdm_slot_reg #(.N(N)) u_shadow0 (.clk(clk), .rst_n(rst_n), .en(shadow_en[0]), .d(in), .q(shadow0_q));
  tdm_slot_reg #(.N(N)) u_shadow1 (.clk(clk), .rst_n(rst_n), .en(shadow_en[1]), .d(in), .q(shadow1_q));
  tdm_slot_reg #(.N(N)) u_shadow2 (.clk(clk), .rst_n(rst_n), .en(shadow_en[2]), .d(in), .q(shadow2_q));

  // The slot-3 word bypasses the shadows so all four outputs load on one edge.
  tdm_slot_reg #(.N(N)) u_out0 (.clk(clk), .rst_n(rst_n), .en(out_en), .d(shadow0_q), .q(out0));
  tdm_slot_reg #(.N(N)) u_out1 (.clk(clk), .rst_n(rst_n), .en(out_en), .d(shadow1_q), .q(out1));
  tdm_slot_reg #(.N(N)) u_out2 (.clk(clk), .rst_n(rst_n), .en(out_en), .d(shadow2_q), .q(out2));
  tdm_slot_reg #(.N(N)) u_out3 (.clk(clk), .rst_n(rst_n), .en(out_en), .d(in),        .q(out3));

  assign slot        = slot_q;
  assign out_valid   = out_valid_q;
  assign frame_error = frame_error_q;

endmodule

// File: tb/tb_tdm_demux4.sv
// Directed scoreboard bench for tdm_demux4: expected frames are queued as
// stimulus is driven and matched whenever out_valid is seen.
module tb_tdm_demux4;

  localparam int N = 4;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] in;
  logic         in_valid;
  logic         frame_start;
  logic [N-1:0] out0, out1, out2, out3;
  logic         out_valid;
  logic [1:0]   slot;
  logic         frame_error;

  int checks   = 0;
  int failures = 0;

  logic [4*N-1:0] expQ[$];

  tdm_demux4 #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n), .in(in), .in_valid(in_valid),
    .frame_start(frame_start), .out0(out0), .out1(out1), .out2(out2),
    .out3(out3), .out_valid(out_valid), .slot(slot), .frame_error(frame_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of input from a negedge; returns at the following negedge.
  task automatic applyStimulus(input logic [N-1:0] d, input logic fs, input logic v);
    in          = d;
    frame_start = fs;
    in_valid    = v;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) applyStimulus('0, 1'b0, 1'b0);
  endtask

  task automatic pushFrame(input logic [N-1:0] a, input logic [N-1:0] b,
                           input logic [N-1:0] c, input logic [N-1:0] d);
    expQ.push_back({a, b, c, d});
  endtask

  // Scoreboard monitor: every out_valid pulse must match the oldest queued frame.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_out_valid", 32'd1, 32'd0);
      end else begin
        logic [4*N-1:0] e;
        e = expQ.pop_front();
        checkOutput("frame_outs", {16'd0, out0, out1, out2, out3}, {16'd0, e});
      end
    end
  end

  initial begin
    rst_n = 1'b0; in = '0; in_valid = 1'b0; frame_start = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset_outs", {16'd0, out0, out1, out2, out3}, 32'd0);
    checkOutput("reset_slot", {30'd0, slot}, 32'd0);
    checkOutput("reset_pulses", {30'd0, out_valid, frame_error}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] single frame");
    applyStimulus(4'd1, 1'b1, 1'b1);
    applyStimulus(4'd2, 1'b0, 1'b1);
    applyStimulus(4'd3, 1'b0, 1'b1);
    checkOutput("single_slot3", {30'd0, slot}, 32'd3);
    pushFrame(4'd1, 4'd2, 4'd3, 4'd4);
    applyStimulus(4'd4, 1'b0, 1'b1);
    checkOutput("single_out_valid", {31'd0, out_valid}, 32'd1);
    checkOutput("single_ferr", {31'd0, frame_error}, 32'd0);
    gap(1);
    checkOutput("single_valid_fall", {31'd0, out_valid}, 32'd0);
    checkOutput("single_hold", {16'd0, out0, out1, out2, out3}, 32'h1234);

    $display("[TB] gapped frame");
    applyStimulus(4'd1, 1'b1, 1'b1);
    checkOutput("gap_slot_a", {30'd0, slot}, 32'd1);
    gap(3);
    checkOutput("gap_slot_hold", {30'd0, slot}, 32'd1);
    applyStimulus(4'd2, 1'b0, 1'b1);
    checkOutput("gap_slot_b", {30'd0, slot}, 32'd2);
    gap(3);
    applyStimulus(4'd3, 1'b0, 1'b1);
    checkOutput("gap_slot_c", {30'd0, slot}, 32'd3);
    gap(3);
    pushFrame(4'd1, 4'd2, 4'd3, 4'd4);
    applyStimulus(4'd4, 1'b0, 1'b1);
    checkOutput("gap_slot_d", {30'd0, slot}, 32'd0);
    checkOutput("gap_out_valid", {31'd0, out_valid}, 32'd1);
    gap(2);

    $display("[TB] back-to-back frames");
    for (int f = 0; f < 2; f++) begin
      logic [N-1:0] base;
      base = 4'(1 + 4 * f);
      applyStimulus(base, 1'b1, 1'b1);
      applyStimulus(base + 4'd1, 1'b0, 1'b1);
      applyStimulus(base + 4'd2, 1'b0, 1'b1);
      pushFrame(base, base + 4'd1, base + 4'd2, base + 4'd3);
      applyStimulus(base + 4'd3, 1'b0, 1'b1);
      checkOutput("b2b_out_valid", {31'd0, out_valid}, 32'd1);
    end
    gap(2);
    checkOutput("b2b_last", {16'd0, out0, out1, out2, out3}, 32'h5678);

    $display("[TB] early start");
    applyStimulus(4'd1, 1'b1, 1'b1);
    applyStimulus(4'd2, 1'b0, 1'b1);
    checkOutput("early_no_err", {31'd0, frame_error}, 32'd0);
    applyStimulus(4'd9, 1'b1, 1'b1);
    checkOutput("early_ferr", {31'd0, frame_error}, 32'd1);
    checkOutput("early_slot", {30'd0, slot}, 32'd1);
    checkOutput("early_hold", {16'd0, out0, out1, out2, out3}, 32'h5678);
    applyStimulus(4'd10, 1'b0, 1'b1);
    checkOutput("early_ferr_fall", {31'd0, frame_error}, 32'd0);
    applyStimulus(4'd11, 1'b0, 1'b1);
    pushFrame(4'd9, 4'd10, 4'd11, 4'd12);
    applyStimulus(4'd12, 1'b0, 1'b1);
    checkOutput("early_out_valid", {31'd0, out_valid}, 32'd1);

    $display("[TB] missing start and hunt");
    applyStimulus(4'd7, 1'b0, 1'b1);
    checkOutput("miss_ferr", {31'd0, frame_error}, 32'd1);
    checkOutput("miss_slot", {30'd0, slot}, 32'd0);
    applyStimulus(4'd3, 1'b0, 1'b1);
    checkOutput("hunt_no_err_a", {31'd0, frame_error}, 32'd0);
    applyStimulus(4'd3, 1'b0, 1'b1);
    checkOutput("hunt_no_err_b", {31'd0, frame_error}, 32'd0);
    checkOutput("hunt_slot", {30'd0, slot}, 32'd0);
    checkOutput("hunt_hold", {16'd0, out0, out1, out2, out3}, 32'h9abc);
    applyStimulus(4'd1, 1'b1, 1'b1);
    applyStimulus(4'd2, 1'b0, 1'b1);
    applyStimulus(4'd3, 1'b0, 1'b1);
    pushFrame(4'd1, 4'd2, 4'd3, 4'd4);
    applyStimulus(4'd4, 1'b0, 1'b1);
    checkOutput("relock_out_valid", {31'd0, out_valid}, 32'd1);
    gap(1);

    $display("[TB] reset mid-frame");
    applyStimulus(4'd1, 1'b1, 1'b1);
    applyStimulus(4'd2, 1'b0, 1'b1);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_async_outs", {16'd0, out0, out1, out2, out3}, 32'd0);
    checkOutput("rst_async_slot", {30'd0, slot}, 32'd0);
    checkOutput("rst_async_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    applyStimulus(4'd3, 1'b0, 1'b1);
    applyStimulus(4'd4, 1'b0, 1'b1);
    checkOutput("post_rst_slot", {30'd0, slot}, 32'd0);
    checkOutput("post_rst_ferr", {31'd0, frame_error}, 32'd0);
    gap(2);
    checkOutput("post_rst_outs", {16'd0, out0, out1, out2, out3}, 32'd0);
    checkOutput("sb_empty", expQ.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
